// File: rtl/shift_arb.sv
// shift_arb: shares one cyclic/logical/arithmetic shifter among NREQ requesters behind a
// one-entry response register. Define SHIFT_ARB_RR_EN for round-robin selection; otherwise fixed priority.
module shift_arb #(
    parameter int N    = 32,
    parameter int NREQ = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*N-1:0]            req_a,
    input  logic [NREQ*$clog2(N)-1:0]    req_b,
    input  logic [NREQ*2-1:0]            req_op,
    output logic                         resp_valid,
    output logic [$clog2(NREQ)-1:0]      resp_id,
    output logic [N-1:0]                 resp_r,
    input  logic [NREQ-1:0]              resp_ready,
    output logic                         busy
);

    localparam int K    = $clog2(N);
    localparam int ID_W = $clog2(NREQ);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      resp_r_q, resp_r_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
`ifdef SHIFT_ARB_RR_EN
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
`endif

    logic              drain;
    logic              can_grant;
    logic              found;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    logic              transfer;
    logic [N-1:0]      sel_a;
    logic [K-1:0]      sel_b;
    logic [1:0]        sel_op;
    logic [N-1:0]      shift_res;

    // Rotation takes the upper half of the doubled operand so b = 0 needs no special case.
    function automatic logic [N-1:0] do_shift(input logic [N-1:0] a,
                                              input logic [K-1:0] b,
                                              input logic [1:0]   op);
        logic [2*N-1:0]      rot;
        logic signed [N-1:0] sra;
        rot = {a, a} << b;
        sra = $signed(a) >>> b;
        case (op)
            2'b00:   return rot[2*N-1:N];
            2'b01:   return a << b;
            2'b10:   return a >> b;
            2'b11:   return sra;
            default: return a;
        endcase
    endfunction

    assign resp_valid = (state_q == FULL);
    assign resp_id    = resp_id_q;
    assign resp_r     = resp_r_q;
    assign busy       = resp_valid;

    // Grant selection; reset masks every grant so nothing is accepted in the reset cycle.
    always_comb begin
        drain     = resp_valid & resp_ready[resp_id_q];
        can_grant = ~resp_valid | drain;
        found     = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
`ifdef SHIFT_ARB_RR_EN
        for (int off = 1; off <= NREQ; off++) begin
            cand = ID_W'((int'(last_grant_q) + off) % NREQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end else begin
                found   = found;
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            cand = ID_W'(i);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end else begin
                found   = found;
            end
        end
`endif
        transfer = can_grant & found & ~reset;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = transfer && (gnt_idx == ID_W'(i));
        end
    end

    // Operand mux and shared shifter for the granted requester.
    always_comb begin
        sel_a     = req_a[int'(gnt_idx)*N +: N];
        sel_b     = req_b[int'(gnt_idx)*K +: K];
        sel_op    = req_op[int'(gnt_idx)*2 +: 2];
        shift_res = do_shift(sel_a, sel_b, sel_op);
    end

    // Next-state for the response stage; a transfer always wins over a drain.
    always_comb begin
        state_d   = state_q;
        resp_r_d  = resp_r_q;
        resp_id_d = resp_id_q;
`ifdef SHIFT_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            EMPTY: begin
                if (transfer) begin
                    state_d = FULL;
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (transfer) begin
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end else begin
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (transfer) begin
            resp_r_d  = shift_res;
            resp_id_d = gnt_idx;
`ifdef SHIFT_ARB_RR_EN
            last_grant_d = gnt_idx;
`endif
        end else begin
            resp_r_d  = resp_r_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            resp_r_q  <= '0;
            resp_id_q <= '0;
`ifdef SHIFT_ARB_RR_EN
            last_grant_q <= ID_W'(NREQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            resp_r_q  <= resp_r_d;
            resp_id_q <= resp_id_d;
`ifdef SHIFT_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_shift_arb.sv
// Directed self-checking bench for shift_arb (N=32, NREQ=4); arbitration section follows SHIFT_ARB_RR_EN.
module tb_shift_arb;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [19:0]  req_b;
    logic [7:0]   req_op;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [31:0]  resp_r;
    logic [3:0]   resp_ready;
    logic         busy;

    int n_cmp;
    int n_bad;

    shift_arb #(.N(32), .NREQ(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_r(resp_r),
        .resp_ready(resp_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [4:0] b, input logic [1:0] op);
        req_a[i*32 +: 32] = a;
        req_b[i*5 +: 5]   = b;
        req_op[i*2 +: 2]  = op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Opcode sweep vectors: requester, a, b, op, expected result.
    int          sw_req [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    logic [31:0] sw_a   [10] = '{32'hF000_000F, 32'hF000_000F, 32'hF000_000F, 32'hF000_000F,
                                 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                                 32'h0000_0001, 32'h8000_0000};
    logic [4:0]  sw_b   [10] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31};
    logic [1:0]  sw_op  [10] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
    logic [31:0] sw_exp [10] = '{32'h0000_00FF, 32'h0000_00F0, 32'h0F00_0000, 32'hFF00_0000,
                                 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                                 32'h8000_0000, 32'hFFFF_FFFF};

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        req_valid  = 4'b0000;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 4'b1111;
        tick();
        tick();
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_resp_r", resp_r, 32'd0);
        check_eq("rst_resp_id", {30'd0, resp_id}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_req_ready", {28'd0, req_ready}, 32'd0);
        reset = 1'b0;

        // Single request: rotate-left by 1.
        set_req(0, 32'h8000_0001, 5'd1, 2'b00);
        req_valid = 4'b0001;
        #1;
        check_eq("single_ready", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0000;
        check_eq("single_valid", {31'd0, resp_valid}, 32'd1);
        check_eq("single_busy", {31'd0, busy}, 32'd1);
        check_eq("single_id", {30'd0, resp_id}, 32'd0);
        check_eq("single_r", resp_r, 32'h0000_0003);

        // Back-to-back opcode sweep, one result per cycle.
        for (int k = 0; k < 10; k++) begin
            set_req(sw_req[k], sw_a[k], sw_b[k], sw_op[k]);
            req_valid = 4'b0001 << sw_req[k];
            #1;
            check_eq($sformatf("sweep%0d_ready", k), {28'd0, req_ready}, 32'd1 << sw_req[k]);
            tick();
            check_eq($sformatf("sweep%0d_id", k), {30'd0, resp_id}, sw_req[k]);
            check_eq($sformatf("sweep%0d_r", k), resp_r, sw_exp[k]);
        end
        req_valid = 4'b0000;
        tick();
        check_eq("drain_empty", {31'd0, resp_valid}, 32'd0);

        // Arbitration, starting from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 32'd100 + i, 5'd0, 2'b01);
`ifdef SHIFT_ARB_RR_EN
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            req_valid = 4'b1111;
            for (int k = 0; k < 5; k++) begin
                #1;
                check_eq($sformatf("rr%0d_ready", k), {28'd0, req_ready}, 32'd1 << order[k]);
                tick();
                check_eq($sformatf("rr%0d_id", k), {30'd0, resp_id}, order[k]);
                check_eq($sformatf("rr%0d_r", k), resp_r, 32'd100 + order[k]);
            end
        end
`else
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("fp%0d_ready", k), {28'd0, req_ready}, 32'h2);
            tick();
            check_eq($sformatf("fp%0d_id", k), {30'd0, resp_id}, 32'd1);
        end
        req_valid = 4'b1000;
        #1;
        check_eq("fp_ready3", {28'd0, req_ready}, 32'h8);
        tick();
        check_eq("fp_id3", {30'd0, resp_id}, 32'd3);
        check_eq("fp_r3", resp_r, 32'd103);
`endif
        req_valid = 4'b0000;
        tick();

        // Backpressure on requester 2's result; other resp_ready bits must be ignored.
        set_req(2, 32'hA5A5_0000, 5'd8, 2'b10);
        set_req(0, 32'h0000_0001, 5'd3, 2'b01);
        req_valid = 4'b0100;
        #1;
        check_eq("bp_grant2", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid  = 4'b0001;
        resp_ready = 4'b1011;
        check_eq("bp_id", {30'd0, resp_id}, 32'd2);
        check_eq("bp_r", resp_r, 32'h00A5_A500);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("bp%0d_ready", k), {28'd0, req_ready}, 32'd0);
            tick();
            check_eq($sformatf("bp%0d_valid", k), {31'd0, resp_valid}, 32'd1);
            check_eq($sformatf("bp%0d_r", k), resp_r, 32'h00A5_A500);
        end
        resp_ready = 4'b0100;
        #1;
        check_eq("bp_release_ready", {28'd0, req_ready}, 32'h1);
        tick();
        check_eq("bp_new_id", {30'd0, resp_id}, 32'd0);
        check_eq("bp_new_r", resp_r, 32'h0000_0008);

        // Reset while a result is held (id 0, resp_ready[0] low) and requests are pending.
        check_eq("pre_rst_valid", {31'd0, resp_valid}, 32'd1);
        resp_ready = 4'b1111;
        req_valid  = 4'b0101;
        reset      = 1'b1;
        #1;
        check_eq("midrst_ready", {28'd0, req_ready}, 32'd0);
        tick();
        check_eq("midrst_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("midrst_r", resp_r, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0000;
        check_eq("post_rst_id", {30'd0, resp_id}, 32'd0);
        check_eq("post_rst_r", resp_r, 32'h0000_0008);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_arb.md
# shift_arb

Round-robin arbiter and sequencer that shares one shift unit among `NREQ` requesters, such as cores or pipeline ports of the multi-core MIPS machine. Each requester presents an operand, shift amount and opcode through a valid/ready handshake. The block grants at most one request per cycle and drives the shared cyclic/logical/arithmetic shift datapath. The tagged result is returned through a one-entry registered response stage with backpressure.

## Interface

Parameters:
- `N`, default 32: datapath width; power of two, ≥ 4.
- `NREQ`, default 4: number of requesters; 2–8.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in `NREQ`: per-requester request valid.
- `req_ready` out `NREQ`: per-requester accept; one-hot or zero.
- `req_a` in `NREQ*N`: operand; requester *i* occupies bits `[i*N +: N]`.
- `req_b` in `NREQ*$clog2(N)`: shift amount; requester *i* occupies `[i*K +: K]`, where K = `$clog2(N)`.
- `req_op` in `NREQ*2`: opcode; 00 = cyclic left, 01 = logical left, 10 = logical right, 11 = arithmetic right.
- `resp_valid` out 1: a result is held in the response register.
- `resp_id` out `$clog2(NREQ)`: index of the requester that owns the result.
- `resp_r` out `N`: shift result.
- `resp_ready` in `NREQ`: per-requester consume; only bit `resp_id` is examined.
- `busy` out 1: equals `resp_valid`.

## Operation

- The FSM has two states: EMPTY and FULL. EMPTY means `resp_valid` = 0; FULL means `resp_valid` = 1.
- Response drain:
  - `drain = resp_valid & resp_ready[resp_id]`.
  - Bits of `resp_ready` other than `resp_id` are ignored.
- Grant eligibility:
  - `can_grant = !resp_valid | drain`.
  - When `can_grant` is 1 and any `req_valid` bit is set, exactly one requester *g* is selected.
  - `req_ready[g]` = 1 in that same cycle, combinationally. All other `req_ready` bits are 0.
  - When `can_grant` is 0, all `req_ready` bits are 0.
- Selection: round-robin starting from `last_grant+1` modulo `NREQ`. `last_grant` updates to *g* on every grant.
- Transfer: when `req_valid[g] & req_ready[g]`, the selected operands pass through the combinational shifter. The result is registered on that edge: `resp_r ← shift(a, b, op)`, `resp_id ← g`, `resp_valid ← 1`.
- Shift arithmetic:
  - Cyclic left: bits leaving the MSB re-enter at the LSB.
  - Logical shifts fill with 0.
  - Arithmetic right fills with `a[N-1]`.
  - A shift amount of 0 returns `a` unchanged for every opcode.
  - `b` is K bits wide, so the maximum shift is N−1.
- FSM transitions:
  - EMPTY → FULL on a transfer.
  - FULL → EMPTY on a drain with no transfer.
  - FULL → FULL on a drain with a simultaneous transfer. This gives back-to-back throughput of one result per cycle.
  - FULL holds when there is no drain. `resp_r` and `resp_id` stay stable while FULL and not drained.
- Requesters must hold `req_a`, `req_b` and `req_op` stable while `req_valid` is 1 and they are not granted. `req_valid` may drop before a grant without side effects.

## Timing

- Latency: a request accepted in cycle *t* produces `resp_valid` = 1 in cycle *t+1*.
- Throughput: one result per cycle while every consumer keeps `resp_ready` high.
- Reset values:
  - `resp_valid` = 0, `resp_r` = 0, `resp_id` = 0, `busy` = 0, `req_ready` = 0.
  - `last_grant` = `NREQ`−1, so requester 0 wins the first round-robin pass.
- Reset mid-operation: a pending result is discarded. A request presented in the reset cycle is not accepted, because `req_ready` is forced to 0 while `reset` is high.
- The only combinational paths are `req_valid`/`resp_ready` → `req_ready`. There is no combinational path from `req_*` data to `resp_*`.

## Configuration

- Macro: `SHIFT_ARB_RR_EN`.
- When defined: round-robin selection as specified above, using the `last_grant` register.
- When undefined:
  - Fixed priority, where the lowest index with `req_valid` set wins.
  - The `last_grant` register is not implemented.
  - All other behaviour is identical.

## Test plan

- Single request, N=32: requester 0 sends a=0x8000_0001, b=1, op=00. Required: `req_ready[0]`=1 in that cycle; next cycle `resp_valid`=1, `resp_id`=0, `resp_r`=0x0000_0003.
- Opcode sweep, each shift with b=4:
  - a=0xF000_000F, op 01 → 0x0000_00F0.
  - a=0xF000_000F, op 10 → 0x0F00_0000.
  - a=0xF000_000F, op 11 → 0xFF00_0000.
  - a=0x1234_5678, b=0, any op → 0x1234_5678.
- Round-robin fairness (`SHIFT_ARB_RR_EN` defined): all 4 requesters hold `req_valid` and `resp_ready` is all 1s. Required grant order 0,1,2,3,0, with one grant per cycle.
- Fixed priority (`SHIFT_ARB_RR_EN` undefined): requesters 1 and 3 both valid. Required: 1 is granted repeatedly until it drops `req_valid`, then 3 is granted.
- Backpressure:
  - Result pending for `resp_id`=2 with `resp_ready[2]`=0 for 3 cycles. Required: all `req_ready`=0 and `resp_r` unchanged during those cycles.
  - Then raise `resp_ready[2]` while requester 0 is valid. Required: a grant in the same cycle, and the new result in the next cycle.
- Reset mid-operation: assert `reset` while `resp_valid`=1 and requests are pending. Required: next cycle `resp_valid`=0 and `resp_r`=0; the first grant after reset goes to requester 0.
